// File: rtl/dccm_lsu.sv
// Load/store unit driving the DCCM wrapper: one request at a time, registered strobes,
// lane extraction and sign/zero extension of load data. Optional misaligned trap: LSU_MISALIGN_TRAP_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | req_ready high, waiting for a request
// S_ISSUE | one-cycle DCCM write or read strobe
// S_WAIT  | read word valid on dccm_rd_data, extract and extend it
// S_RESP  | load result held on resp_* until writeback accepts it
module dccm_lsu #(
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RD_W-1:0]   resp_rd,
  output logic [31:0]       resp_data,
  output logic              resp_err,
  output logic              dccm_wr_en,
  output logic              dccm_rd_en,
  output logic [31:0]       dccm_wr_addr,
  output logic [31:0]       dccm_rd_addr,
  output logic [31:0]       dccm_wr_data,
  output logic [1:0]        store_type,
  output logic [1:0]        store_offset,
  input  logic [31:0]       dccm_rd_data
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state;
  logic              we_q;
  logic              unsigned_q;
  logic              accept;
  logic              misalign;
  logic [1:0]        size_norm;
  logic [ADDR_W-1:0] word_addr;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;
  logic [31:0]       load_ext;

  assign accept    = req_valid && req_ready;
  assign size_norm = (req_size == 2'b11) ? 2'b10 : req_size;
  assign word_addr = req_addr >> 2;

`ifdef LSU_MISALIGN_TRAP_EN
  logic resp_err_q;

  assign misalign = ((size_norm == 2'b01) && req_addr[0]) ||
                    ((size_norm == 2'b10) && (req_addr[1:0] != 2'b00));
  assign resp_err = resp_err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_err_q <= 1'b0;
    end else if (accept) begin
      resp_err_q <= misalign;
    end else if ((state == S_RESP) && (resp_ready || flush)) begin
      resp_err_q <= 1'b0;
    end
  end
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  // store_type/store_offset double as the captured size/offset for load extraction
  always_comb begin
    lane_b = 8'h00;
    case (store_offset)
      2'd0:    lane_b = dccm_rd_data[7:0];
      2'd1:    lane_b = dccm_rd_data[15:8];
      2'd2:    lane_b = dccm_rd_data[23:16];
      default: lane_b = dccm_rd_data[31:24];
    endcase
    lane_h = store_offset[1] ? dccm_rd_data[31:16] : dccm_rd_data[15:0];
    case (store_type)
      2'b00:   load_ext = unsigned_q ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = unsigned_q ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = dccm_rd_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      req_ready    <= 1'b0;
      we_q         <= 1'b0;
      unsigned_q   <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rd      <= '0;
      resp_data    <= 32'h0;
      dccm_wr_en   <= 1'b0;
      dccm_rd_en   <= 1'b0;
      dccm_wr_addr <= 32'h0;
      dccm_rd_addr <= 32'h0;
      dccm_wr_data <= 32'h0;
      store_type   <= 2'b00;
      store_offset <= 2'b00;
    end else begin
      dccm_wr_en <= 1'b0;
      dccm_rd_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_ready    <= 1'b0;
            we_q         <= req_we;
            unsigned_q   <= req_unsigned;
            store_type   <= size_norm;
            store_offset <= req_addr[1:0];
            if (misalign) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_data  <= 32'h0;
              resp_rd    <= req_rd;
            end else if (req_we) begin
              state        <= S_ISSUE;
              dccm_wr_en   <= 1'b1;
              dccm_wr_addr <= 32'(word_addr);
              dccm_wr_data <= req_wdata;
            end else begin
              state        <= S_ISSUE;
              dccm_rd_en   <= 1'b1;
              dccm_rd_addr <= 32'(word_addr);
              resp_rd      <= req_rd;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        S_ISSUE: begin
          // a store is committed once accepted, so flush only matters for loads
          if (we_q || flush) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (flush) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
          end else begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_data  <= load_ext;
          end
        end
        S_RESP: begin
          if (resp_ready || flush) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dccm_lsu.sv
// Directed, table-driven bench for dccm_lsu with hand sequences for flush, stall and reset.
// Trap checks run only when LSU_MISALIGN_TRAP_EN is defined.
module tb_dccm_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        dccm_wr_en;
  logic        dccm_rd_en;
  logic [31:0] dccm_wr_addr;
  logic [31:0] dccm_rd_addr;
  logic [31:0] dccm_wr_data;
  logic [1:0]  store_type;
  logic [1:0]  store_offset;
  logic [31:0] dccm_rd_data = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dccm_lsu #(.ADDR_W(32), .RD_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_err(resp_err),
    .dccm_wr_en(dccm_wr_en), .dccm_rd_en(dccm_rd_en), .dccm_wr_addr(dccm_wr_addr),
    .dccm_rd_addr(dccm_rd_addr), .dccm_wr_data(dccm_wr_data), .store_type(store_type),
    .store_offset(store_offset), .dccm_rd_data(dccm_rd_data)
  );

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_type;
    logic        mis;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      n_checks++;
      if (dccm_wr_en && dccm_rd_en) begin
        n_fail++;
        $display("FAIL strobes_exclusive: got wr=1 rd=1 expected at most one at %0t", $time);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check("ready_timeout", {31'h0, req_ready}, 32'h1);
  endtask

  // Leaves the bench #1 after the accepting edge, i.e. in cycle T+1.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    wait_ready();
    req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_rd = rd;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    req_wdata = 32'h5A5A5A5A;
    req_addr = 32'hFFFFFFFF;
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.we, v.size, v.uns, v.addr, v.wdata, v.rd);
    dccm_rd_data = 32'hA5A5A5A5;
    if (v.we) begin
      check("st_wr_en", {31'h0, dccm_wr_en}, 32'h1);
      check("st_rd_en", {31'h0, dccm_rd_en}, 32'h0);
      check("st_wr_addr", dccm_wr_addr, v.exp_addr);
      check("st_wr_data", dccm_wr_data, v.exp_data);
      check("st_type", {30'h0, store_type}, {30'h0, v.exp_type});
      check("st_offset", {30'h0, store_offset}, {30'h0, v.addr[1:0]});
      step();
      check("st_wr_en_drop", {31'h0, dccm_wr_en}, 32'h0);
      check("st_ready_t2", {31'h0, req_ready}, 32'h1);
      check("st_no_resp", {31'h0, resp_valid}, 32'h0);
    end else begin
      check("ld_rd_en", {31'h0, dccm_rd_en}, 32'h1);
      check("ld_wr_en", {31'h0, dccm_wr_en}, 32'h0);
      check("ld_rd_addr", dccm_rd_addr, v.exp_addr);
      check("ld_offset", {30'h0, store_offset}, {30'h0, v.addr[1:0]});
      step();
      dccm_rd_data = v.rdata;
      check("ld_rd_en_drop", {31'h0, dccm_rd_en}, 32'h0);
      check("ld_valid_t2", {31'h0, resp_valid}, 32'h0);
      step();
      dccm_rd_data = 32'hA5A5A5A5;
      check("ld_valid_t3", {31'h0, resp_valid}, 32'h1);
      check("ld_data", resp_data, v.exp_data);
      check("ld_rd", {27'h0, resp_rd}, {27'h0, v.rd});
      check("ld_err", {31'h0, resp_err}, 32'h0);
      check("ld_ready_busy", {31'h0, req_ready}, 32'h0);
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check("ld_valid_drop", {31'h0, resp_valid}, 32'h0);
      check("ld_ready_back", {31'h0, req_ready}, 32'h1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    //          we    size   uns   addr          wdata         rd     rdata         exp_addr      exp_data      type   mis
    vt[0] = '{1'b1, 2'b10, 1'b0, 32'h00000104, 32'hDEADBEEF, 5'd0,  32'h0,        32'h00000041, 32'hDEADBEEF, 2'b10, 1'b0};
    vt[1] = '{1'b0, 2'b00, 1'b0, 32'h00000107, 32'h0,        5'd3,  32'h80112233, 32'h00000041, 32'hFFFFFF80, 2'b00, 1'b0};
    vt[2] = '{1'b0, 2'b00, 1'b1, 32'h00000107, 32'h0,        5'd4,  32'h80112233, 32'h00000041, 32'h00000080, 2'b00, 1'b0};
    vt[3] = '{1'b0, 2'b01, 1'b0, 32'h00000106, 32'h0,        5'd5,  32'h80112233, 32'h00000041, 32'hFFFF8011, 2'b01, 1'b0};
    vt[4] = '{1'b1, 2'b00, 1'b0, 32'h7F030000, 32'h000000FF, 5'd0,  32'h0,        32'h1FC0C000, 32'h000000FF, 2'b00, 1'b0};
    vt[5] = '{1'b0, 2'b01, 1'b1, 32'h00000100, 32'h0,        5'd9,  32'h1234ABCD, 32'h00000040, 32'h0000ABCD, 2'b01, 1'b0};
    vt[6] = '{1'b0, 2'b10, 1'b0, 32'h00000200, 32'h0,        5'd31, 32'hCAFEF00D, 32'h00000080, 32'hCAFEF00D, 2'b10, 1'b0};
    vt[7] = '{1'b0, 2'b00, 1'b0, 32'h00000101, 32'h0,        5'd12, 32'h1234F67F, 32'h00000040, 32'hFFFFFFF6, 2'b00, 1'b0};
    vt[8] = '{1'b1, 2'b11, 1'b0, 32'h00000010, 32'h01020304, 5'd0,  32'h0,        32'h00000004, 32'h01020304, 2'b10, 1'b0};
    vt[9] = '{1'b0, 2'b01, 1'b0, 32'h00000103, 32'h0,        5'd17, 32'h9ABC5678, 32'h00000040, 32'hFFFF9ABC, 2'b01, 1'b1};

    // reset state
    step(); step();
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_strobes", {30'h0, dccm_wr_en, dccm_rd_en}, 32'h0);
    check("rst_wr_addr", dccm_wr_addr, 32'h0);
    check("rst_resp_data", resp_data, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
`ifdef LSU_MISALIGN_TRAP_EN
      if (vt[i].mis) continue;
`endif
      run_vec(vt[i]);
    end

    // flush during ISSUE: read strobe still fires, no response
    issue(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 5'd6);
    check("fi_rd_en", {31'h0, dccm_rd_en}, 32'h1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fi_ready", {31'h0, req_ready}, 32'h1);
    check("fi_valid", {31'h0, resp_valid}, 32'h0);
    step();
    check("fi_valid2", {31'h0, resp_valid}, 32'h0);

    // flush during WAIT
    issue(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 5'd6);
    step();
    dccm_rd_data = 32'h11111111;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fw_valid", {31'h0, resp_valid}, 32'h0);
    check("fw_ready", {31'h0, req_ready}, 32'h1);
    step();
    check("fw_valid2", {31'h0, resp_valid}, 32'h0);

    // flush in IDLE ignored; stall 5 cycles in RESP; then flush+resp_ready together
    flush = 1'b1;
    issue(1'b0, 2'b10, 1'b0, 32'h00000300, 32'h0, 5'd7);
    flush = 1'b0;
    step();
    dccm_rd_data = 32'h13579BDF;
    step();
    dccm_rd_data = 32'h0;
    for (int k = 0; k < 5; k++) begin
      check("hold_valid", {31'h0, resp_valid}, 32'h1);
      check("hold_data", resp_data, 32'h13579BDF);
      check("hold_rd", {27'h0, resp_rd}, 32'd7);
      check("hold_ready", {31'h0, req_ready}, 32'h0);
      step();
    end
    flush = 1'b1;
    resp_ready = 1'b1;
    step();
    flush = 1'b0;
    resp_ready = 1'b0;
    check("fr_both_valid", {31'h0, resp_valid}, 32'h0);
    check("fr_both_ready", {31'h0, req_ready}, 32'h1);

    // flush alone in RESP
    issue(1'b0, 2'b00, 1'b1, 32'h00000302, 32'h0, 5'd8);
    step();
    dccm_rd_data = 32'h00440000;
    step();
    check("fr_valid_on", {31'h0, resp_valid}, 32'h1);
    check("fr_data", resp_data, 32'h00000044);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fr_valid_off", {31'h0, resp_valid}, 32'h0);
    check("fr_ready", {31'h0, req_ready}, 32'h1);

`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b0, 2'b10, 1'b0, 32'h00000102, 32'h0, 5'd3);
    check("tr_valid", {31'h0, resp_valid}, 32'h1);
    check("tr_err", {31'h0, resp_err}, 32'h1);
    check("tr_data", resp_data, 32'h0);
    check("tr_rd", {27'h0, resp_rd}, 32'd3);
    check("tr_strobes", {30'h0, dccm_wr_en, dccm_rd_en}, 32'h0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("tr_valid_off", {31'h0, resp_valid}, 32'h0);
    check("tr_err_off", {31'h0, resp_err}, 32'h0);
    issue(1'b1, 2'b01, 1'b0, 32'h00000101, 32'h0000BEEF, 5'd2);
    check("trs_valid", {31'h0, resp_valid}, 32'h1);
    check("trs_err", {31'h0, resp_err}, 32'h1);
    check("trs_wr_en", {31'h0, dccm_wr_en}, 32'h0);
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    check("trs_valid_off", {31'h0, resp_valid}, 32'h0);
`endif

    // reset mid-load
    issue(1'b0, 2'b10, 1'b0, 32'h00000400, 32'h0, 5'd9);
    check("rm_rd_en", {31'h0, dccm_rd_en}, 32'h1);
    rst_n = 1'b0;
    step();
    check("rm_ready", {31'h0, req_ready}, 32'h0);
    check("rm_strobes", {30'h0, dccm_wr_en, dccm_rd_en}, 32'h0);
    check("rm_rd_addr", dccm_rd_addr, 32'h0);
    check("rm_wr_addr", dccm_wr_addr, 32'h0);
    check("rm_wr_data", dccm_wr_data, 32'h0);
    check("rm_type_off", {28'h0, store_type, store_offset}, 32'h0);
    check("rm_resp", {26'h0, resp_valid, resp_rd}, 32'h0);
    check("rm_resp_data", resp_data, 32'h0);
    check("rm_resp_err", {31'h0, resp_err}, 32'h0);
    rst_n = 1'b1;
    step(); step();
    check("rm_ready_back", {31'h0, req_ready}, 32'h1);
    check("rm_no_resp", {31'h0, resp_valid}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
